// File: rtl/case_4_pkg.sv
// Shared definitions for the case_4 datapath stages.
// Covers product and output widths, output limits and FSM state encodings.
package case_4_pkg;

  localparam int PROD_WIDTH = 26;
  localparam int OUT_WIDTH  = 16;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = 16'sh7FFF;  //  32767
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = 16'sh8000;  // -32768

  typedef logic [0:0] state_t;
  localparam state_t ACCUM = 1'b0;
  localparam state_t HOLD  = 1'b1;

endpackage

// File: rtl/case_4_round_sat.sv
// Round-half-up, arithmetic shift right by SHIFT, then saturate to OUT_WIDTH signed.
// Purely combinational; shared by the case_4 requantizing stages.
module case_4_round_sat #(
  parameter int ACC_WIDTH = 32,
  parameter int SHIFT     = 10,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic signed [OUT_WIDTH-1:0] data,
  output logic                        sat
);

  localparam int EXT_WIDTH = ACC_WIDTH + 1;

  localparam logic signed [EXT_WIDTH-1:0] BIAS  = EXT_WIDTH'(1) << (SHIFT - 1);
  localparam logic signed [EXT_WIDTH-1:0] R_MAX = EXT_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [EXT_WIDTH-1:0] R_MIN = -R_MAX - EXT_WIDTH'(1);

  logic signed [EXT_WIDTH-1:0] biased;
  logic signed [EXT_WIDTH-1:0] shifted;

  // One guard bit keeps the bias add from wrapping at the top of the range.
  assign biased  = {sum[ACC_WIDTH-1], sum} + BIAS;
  assign shifted = biased >>> SHIFT;

  always_comb begin
    data = shifted[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (shifted > R_MAX) begin
      data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (shifted < R_MIN) begin
      data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/case_4_acc_round_sat.sv
// Accumulates NUM_TERMS signed products, then rounds, shifts and saturates the sum.
// Valid/ready on both sides; the result is held until the consumer takes it.
module case_4_acc_round_sat #(
  parameter int PROD_WIDTH = case_4_pkg::PROD_WIDTH,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_TERMS  = 8,
  parameter int SHIFT      = 10,
  parameter int OUT_WIDTH  = case_4_pkg::OUT_WIDTH
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         out_valid,
  input  logic                         out_ready
);

  import case_4_pkg::*;

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  state_t                        state_reg, state_next;
  logic signed [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]              cnt_reg, cnt_next;
  logic signed [OUT_WIDTH-1:0]   data_reg, data_next;
  logic                          sat_reg, sat_next;

  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [OUT_WIDTH-1:0]   rs_data;
  logic                          rs_sat;
  logic                          take;

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == HOLD);
  assign out_data  = data_reg;
  assign out_sat   = sat_reg;

  assign take = in_valid && in_ready;
  assign sum  = acc_reg + {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};

  case_4_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .sum  (sum),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    sat_next   = sat_reg;
    case (state_reg)
      ACCUM: begin
        if (take) begin
          if (cnt_reg == LAST_CNT) begin
            data_next  = rs_data;
            sat_next   = rs_sat;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = HOLD;
          end else begin
            acc_next = sum;
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // The release cycle accepts no input; ACCUM resumes on the next edge.
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      sat_reg   <= sat_next;
    end
  end

endmodule

// File: tb/tb_case_4_acc_round_sat.sv
// Bench for case_4_acc_round_sat: vector table plus hand-written handshake, gap and reset sequences.
// Expected results are queued when stimulus is driven and compared when the output handshake completes.
module tb_case_4_acc_round_sat;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic signed [25:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_results = 0;

  typedef struct {
    logic signed [15:0] data;
    logic               sat;
  } exp_t;

  typedef struct {
    string name;
    int    t0;
    int    trest;
    int    exp_data;
    bit    exp_sat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs [12];

  case_4_acc_round_sat dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Scoreboard side: compare every completed output handshake.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && out_valid && out_ready) begin
      n_results++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got data %0d sat %0d, want no output", out_data, out_sat);
      end else begin
        e = sb.pop_front();
        $display("result %0d: data=%0d sat=%0d (want %0d sat %0d)", n_results, out_data, out_sat, e.data, e.sat);
        check("result_data", out_data, e.data);
        check("result_sat", {63'd0, out_sat}, {63'd0, e.sat});
      end
    end
  end

  task automatic expect_result(input int d, input bit s);
    exp_t e;
    e.data = 16'(d);
    e.sat  = s;
    sb.push_back(e);
  endtask

  // Presents one term and returns #1 after the edge that transferred it.
  task automatic send(input int v);
    bit done;
    done = 1'b0;
    in_data  = 26'(v);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge ap_clk);
      if (in_ready) done = 1'b1;
      @(posedge ap_clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready low for 50 cycles, want a transfer of %0d", v);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic send_result(input int t0, input int trest, input int d, input bit s);
    expect_result(d, s);
    send(t0);
    for (int k = 1; k < 8; k++) send(trest);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"basic_1024",    1024,      1024,      8,      1'b0};
    vecs[1]  = '{"round_1536",    1536,      0,         2,      1'b0};
    vecs[2]  = '{"round_m1536",   -1536,     0,         -1,     1'b0};
    vecs[3]  = '{"tie_m512",      -512,      0,         0,      1'b0};
    vecs[4]  = '{"sat_pos",       16777216,  16777216,  32767,  1'b1};
    vecs[5]  = '{"sat_neg",       -33554432, -33554432, -32768, 1'b1};
    vecs[6]  = '{"tie_512",       512,       0,         1,      1'b0};
    vecs[7]  = '{"below_511",     511,       0,         0,      1'b0};
    vecs[8]  = '{"neg_m513",      -513,      0,         -1,     1'b0};
    vecs[9]  = '{"max_exact",     33553919,  0,         32767,  1'b0};
    vecs[10] = '{"max_over",      33554431,  0,         32767,  1'b1};
    vecs[11] = '{"min_exact",     -33554432, 0,         -32768, 1'b0};

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(posedge ap_clk);
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'sd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'sd1);
    check("reset_out_data", out_data, 64'sd0);
    check("reset_out_sat", {63'd0, out_sat}, 64'sd0);
    ap_rst_n = 1'b1;
    idle(1);

    // Latency and single-cycle out_valid with out_ready held high.
    expect_result(8, 1'b0);
    for (int k = 0; k < 7; k++) send(1024);
    check("t1_no_early_valid", {63'd0, out_valid}, 64'sd0);
    send(1024);
    in_valid = 1'b0;
    check("t1_valid_after_last", {63'd0, out_valid}, 64'sd1);
    check("t1_in_ready_low", {63'd0, in_ready}, 64'sd0);
    @(posedge ap_clk);
    #1;
    check("t1_valid_one_cycle", {63'd0, out_valid}, 64'sd0);
    check("t1_in_ready_back", {63'd0, in_ready}, 64'sd1);
    idle(1);

    for (int v = 0; v < 12; v++) begin
      $display("vector %s: %0d then 7x %0d", vecs[v].name, vecs[v].t0, vecs[v].trest);
      send_result(vecs[v].t0, vecs[v].trest, vecs[v].exp_data, vecs[v].exp_sat);
      idle(2);
    end

    // Backpressure: the result must hold still and the offered term must be ignored.
    out_ready = 1'b0;
    send_result(3000, 0, 3, 1'b0);
    in_data  = 26'sd777;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", {63'd0, out_valid}, 64'sd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'sd0);
      check("bp_out_data", out_data, 64'sd3);
      check("bp_out_sat", {63'd0, out_sat}, 64'sd0);
      @(posedge ap_clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    check("bp_released", {63'd0, out_valid}, 64'sd0);
    send_result(1024, 1024, 8, 1'b0);
    idle(2);

    // Random gaps between terms.
    expect_result(1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      idle($urandom_range(0, 3));
      send(100);
    end
    in_valid = 1'b0;
    idle(2);

    // Reset in the middle of an accumulation discards the partial sum.
    for (int k = 0; k < 3; k++) send(5000);
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'sd0);
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'sd1);
    send_result(1024, 1024, 8, 1'b0);
    idle(2);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge ap_clk);
    check("scoreboard_drained", sb.size(), 64'sd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
